// File: rtl/aoi_vector_checker.sv
// Exhaustive stimulus/response checker for a 4-input AOI gate y = ~((a&b)|(c&d)).
// Steps {a,b,c,d} through 0..15, holds each HOLD_CYCLES cycles, and scores y_in on the last held cycle.
module aoi_vector_checker #(
    parameter int HOLD_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic       fail_seen
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_idx;
    logic [7:0] r_hold;

    logic       w_expect;
    logic       w_mismatch;
    logic [4:0] w_err_next;
    logic [3:0] w_idx_next;

    assign w_expect   = ~((a & b) | (c & d));
    assign w_mismatch = (y_in != w_expect);
    assign w_err_next = err_count + {4'b0000, w_mismatch};
    assign w_idx_next = r_idx + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_idx          <= 4'd0;
            r_hold         <= 8'd0;
            {a, b, c, d}   <= 4'b0000;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 5'd0;
            first_fail_vec <= 4'd0;
            fail_seen      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state        <= RUN;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= 5'd0;
                        fail_seen      <= 1'b0;
                        first_fail_vec <= 4'd0;
                        r_idx          <= 4'd0;
                        r_hold         <= 8'd0;
                        {a, b, c, d}   <= 4'b0000;
                    end
                end
                RUN: begin
                    if (r_hold != HOLD_LAST) begin
                        r_hold <= r_hold + 8'd1;
                    end else begin
                        // Sample edge: score the vector that has been held for the full settle time
                        err_count <= w_err_next;
                        if (w_mismatch && !fail_seen) begin
                            first_fail_vec <= {a, b, c, d};
                            fail_seen      <= 1'b1;
                        end
                        r_hold <= 8'd0;
                        if (r_idx != 4'hF) begin
                            r_idx        <= w_idx_next;
                            {a, b, c, d} <= w_idx_next;
                        end else begin
                            r_state      <= DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            pass         <= (w_err_next == 5'd0);
                            {a, b, c, d} <= 4'b0000;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aoi_vector_checker.sv
// Bench for aoi_vector_checker: a behavioural gate model feeds y_in, run results are
// scored against a table of expected outcomes through a queue.
module tb_aoi_vector_checker;

    typedef struct {
        logic [1:0] mode;   // 0 correct AOI, 1 stuck-0, 2 stuck-1, 3 inverted
        logic [4:0] err;
        logic [3:0] ffv;
        logic       fs;
        logic       pass;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
    logic [1:0] mode;
    logic sel;

    logic a0, b0, c0, d0, busy0, done0, pass0, fs0, y0;
    logic [4:0] err0;
    logic [3:0] ffv0;
    logic a1, b1, c1, d1, busy1, done1, pass1, fs1, y1;
    logic [4:0] err1;
    logic [3:0] ffv1;

    logic       c_busy, c_done, c_pass, c_fs;
    logic [4:0] c_err;
    logic [3:0] c_ffv, c_vec;

    int checks = 0;
    int errors = 0;
    rec_t exp_q[$];
    rec_t tbl[4];

    always #5 clk = ~clk;

    function automatic logic model_y(input logic [1:0] m, input logic [3:0] v);
        logic aoi;
        aoi = ~((v[3] & v[2]) | (v[1] & v[0]));
        case (m)
            2'd0:    return aoi;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return ~aoi;
        endcase
    endfunction

    assign y0 = model_y(mode, {a0, b0, c0, d0});
    assign y1 = model_y(mode, {a1, b1, c1, d1});

    aoi_vector_checker #(.HOLD_CYCLES(3)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .y_in(y0),
        .a(a0), .b(b0), .c(c0), .d(d0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail_vec(ffv0), .fail_seen(fs0)
    );

    aoi_vector_checker #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffv1), .fail_seen(fs1)
    );

    always_comb begin
        if (sel) begin
            c_busy = busy1; c_done = done1; c_pass = pass1; c_fs = fs1;
            c_err = err1; c_ffv = ffv1; c_vec = {a1, b1, c1, d1};
        end else begin
            c_busy = busy0; c_done = done0; c_pass = pass0; c_fs = fs0;
            c_err = err0; c_ffv = ffv0; c_vec = {a0, b0, c0, d0};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic s, input logic v);
        if (s) start1 = v;
        else   start0 = v;
    endtask

    // One full run on the selected instance; restart_at != 0 re-pulses start at that edge.
    task automatic do_run(input logic s, input rec_t r, input int restart_at);
        int   hc;
        int   n;
        bit   seq_ok;
        bit   got_done;
        rec_t e;
        hc = s ? 1 : 3;
        sel = s;
        mode = r.mode;
        @(negedge clk);
        set_start(s, 1'b1);
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        chk("start_busy", c_busy, 1);
        chk("start_done_clr", c_done, 0);
        chk("start_err_clr", c_err, 0);
        chk("start_vec0", c_vec, 0);
        seq_ok = 1'b1;
        got_done = 1'b0;
        n = 0;
        while (n < 16 * hc + 20) begin
            set_start(s, (restart_at != 0) && (n + 1 == restart_at));
            @(posedge clk);
            #1;
            n++;
            if (c_done) begin
                got_done = 1'b1;
                break;
            end
            if (c_vec != 4'(n / hc)) seq_ok = 1'b0;
        end
        set_start(s, 1'b0);
        chk("vector_sequence", seq_ok, 1);
        chk("done_edge", got_done ? n : -1, 16 * hc);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk("err_count", c_err, e.err);
        chk("first_fail_vec", c_ffv, e.ffv);
        chk("fail_seen", c_fs, e.fs);
        chk("pass", c_pass, e.pass);
        chk("done_busy", c_busy, 0);
        chk("done_vec", c_vec, 0);
        repeat (2) @(negedge clk);
        chk("done_hold", c_done, 1);
        chk("err_hold", c_err, e.err);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'd0, 5'd0,  4'b0000, 1'b0, 1'b1};
        tbl[1] = '{2'd1, 5'd9,  4'b0000, 1'b1, 1'b0};
        tbl[2] = '{2'd2, 5'd7,  4'b0011, 1'b1, 1'b0};
        tbl[3] = '{2'd3, 5'd16, 4'b0000, 1'b1, 1'b0};

        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode = 2'd0;
        sel = 1'b0;
        #12;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_ffv", ffv0, 0);
        chk("rst_fail_seen", fs0, 0);
        chk("rst_vec", {a0, b0, c0, d0}, 0);
        chk("rst_busy_h1", busy1, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) do_run(1'b0, tbl[i], 0);

        // start during RUN must not restart or clear the run
        do_run(1'b0, tbl[1], 10);
        // start from DONE after a failing run clears results
        do_run(1'b0, tbl[0], 0);

        // Asynchronous reset while vector 5 is driven
        sel = 1'b0;
        mode = 2'd1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("pre_rst_vec", {a0, b0, c0, d0}, 5);
        chk("pre_rst_err", err0, 4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_vec", {a0, b0, c0, d0}, 0);
        chk("async_rst_busy", busy0, 0);
        chk("async_rst_err", err0, 0);
        chk("async_rst_fail_seen", fs0, 0);
        @(negedge clk);
        rst = 1'b0;
        do_run(1'b0, tbl[0], 0);

        // Minimum hold time instance
        do_run(1'b1, tbl[0], 0);
        do_run(1'b1, tbl[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
